unified_memory_ctrl: RTL

UNIFIED_MEMORY_CTRL -- requirements
Module: unified_memory_ctrl

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/byte_en_ram.sv | 44 ++++
 rtl/unified_memory_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and helpers for the unified memory controller
// Contents: FSM state enum, error-cause enum, byte-lane count function.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    MISALIGN,
    RO_WRITE,
    RANGE
  } err_cause_e;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// rtl/byte_en_ram.sv - synchronous single-port data RAM with per-byte write enables
// Ports:
//   clk    in   rising-edge clock
//   we     in   write strobe
//   re     in   read strobe; rdata updates on the same edge
//   addr   in   word address
//   be     in   byte enables, bit i covers wdata[8i+7:8i]
//   wdata  in   write data
//   rdata  out  registered read data
module byte_en_ram
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic                               re,
  input  logic [ADDR_BITS-1:0]               addr,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  be,
  input  logic [DATA_WIDTH-1:0]              wdata,
  output logic [DATA_WIDTH-1:0]              rdata
);

  localparam int NB = byte_lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents survive controller reset, so the array has no reset term.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/unified_memory_ctrl.sv
// rtl/unified_memory_ctrl.sv - single-outstanding controller over instruction ROM and data RAM
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   access request, sampled only in IDLE
//   wr_en    in   1 = write, 0 = read
//   addr     in   byte address, MSB 1 = data region, 0 = instruction region
//   wr_data  in   write data
//   byte_en  in   per-byte write enable
//   ready    out  one-cycle response strobe
//   rd_data  out  read data, zero unless ready
//   err      out  access error, zero unless ready
module unified_memory_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int   DATA_WIDTH    = 32,
  parameter int   ADDR_WIDTH    = 32,
  parameter int   INSTR_DEPTH   = 1024,
  parameter int   DATA_DEPTH    = 1024,
  parameter int   WAIT_STATES   = 1,
  parameter       MEMORY_FORMAT = "hex",
  // ROM image, produced from the init file (in MEMORY_FORMAT) at elaboration.
  parameter logic [DATA_WIDTH-1:0] ROM_INIT [INSTR_DEPTH] = '{default: '0}
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  byte_en,
  output logic                               ready,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               err
);

  localparam int NB  = byte_lanes(DATA_WIDTH);
  localparam int OFF = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - 1 - OFF;
  localparam int RAW = (DATA_DEPTH  > 1) ? $clog2(DATA_DEPTH)  : 1;
  localparam int ROW = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;

  if ((DATA_WIDTH % 8) != 0 || WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_param_err
    $error("unified_memory_ctrl: illegal DATA_WIDTH or WAIT_STATES");
  end
  if (MEMORY_FORMAT != "hex" && MEMORY_FORMAT != "bin") begin : g_fmt_err
    $error("unified_memory_ctrl: MEMORY_FORMAT must be hex or bin");
  end

  state_e                  state, state_nx;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic                    cap_wr;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [NB-1:0]           cap_be;

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    cur_wr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [NB-1:0]           cur_be;
  logic [IW-1:0]           cur_idx;
  logic                    cur_dreg;
  err_cause_e              cause;
  logic                    go_resp;

  logic                    rsp_err, rsp_rd, rsp_dreg;
  logic [DATA_WIDTH-1:0]   rom_q, ram_q;
  logic                    ram_we, ram_re;

  // With zero wait states the access completes on the accepting edge, so
  // decode works on the live inputs in IDLE and on the captured copy after.
  assign cur_addr = (state == IDLE) ? addr    : cap_addr;
  assign cur_wr   = (state == IDLE) ? wr_en   : cap_wr;
  assign cur_data = (state == IDLE) ? wr_data : cap_data;
  assign cur_be   = (state == IDLE) ? byte_en : cap_be;
  assign cur_idx  = cur_addr[ADDR_WIDTH-2:OFF];
  assign cur_dreg = cur_addr[ADDR_WIDTH-1];

  always_comb begin
    cause = NONE;
    if (|(cur_addr & ADDR_WIDTH'(NB - 1))) begin
      cause = MISALIGN;
    end else if (!cur_dreg && cur_wr) begin
      cause = RO_WRITE;
    end else if (cur_dreg ? (64'(cur_idx) >= 64'(DATA_DEPTH))
                          : (64'(cur_idx) >= 64'(INSTR_DEPTH))) begin
      cause = RANGE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    go_resp  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nx = RESP;
            go_resp  = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = RESP;
          go_resp  = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      cap_addr <= '0;
      cap_wr   <= 1'b0;
      cap_data <= '0;
      cap_be   <= '0;
    end else if (state == IDLE && req) begin
      cnt      <= 4'(WAIT_STATES);
      cap_addr <= addr;
      cap_wr   <= wr_en;
      cap_data <= wr_data;
      cap_be   <= byte_en;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // rst_n gates the RAM strobes so a request seen while reset is held
  // can never reach the array.
  assign ram_we = rst_n & go_resp & (cause == NONE) &  cur_wr & cur_dreg;
  assign ram_re = rst_n & go_resp & (cause == NONE) & ~cur_wr & cur_dreg;

  byte_en_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DATA_DEPTH),
    .ADDR_BITS  (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_idx[RAW-1:0]),
    .be    (cur_be),
    .wdata (cur_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err  <= 1'b0;
      rsp_rd   <= 1'b0;
      rsp_dreg <= 1'b0;
      rom_q    <= '0;
    end else if (go_resp) begin
      rsp_err  <= (cause != NONE);
      rsp_rd   <= (cause == NONE) && !cur_wr;
      rsp_dreg <= cur_dreg;
      rom_q    <= cur_dreg ? '0 : ROM_INIT[cur_idx[ROW-1:0]];
    end
  end

  assign ready   = (state == RESP);
  assign err     = ready & rsp_err;
  assign rd_data = (ready && rsp_rd) ? (rsp_dreg ? ram_q : rom_q) : '0;

endmodule
